// File: rtl/axis_demux_tdest_if.sv
// AXI4-Stream bundle carrying N lanes packed side by side.
// The slave modport is the receiving side; the master modport is the sending side.
interface axis_demux_tdest_if #(
    parameter int N          = 1,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 3,
    parameter int USER_WIDTH = 1
);
    logic [N*DATA_WIDTH-1:0] tdata;
    logic [N*KEEP_WIDTH-1:0] tkeep;
    logic [N-1:0]            tvalid;
    logic [N-1:0]            tready;
    logic [N-1:0]            tlast;
    logic [N*ID_WIDTH-1:0]   tid;
    logic [N*DEST_WIDTH-1:0] tdest;
    logic [N*USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_demux_tdest.sv
// Frame demux steering by first-beat tdest into per-output 2-entry skid registers.
// Optional AXIS_DEMUX_DROP_COUNT_EN adds a saturating dropped-frame counter.
module axis_demux_tdest #(
    parameter int M_COUNT          = 4,
    parameter int DATA_WIDTH       = 8,
    parameter bit KEEP_ENABLE      = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH       = (DATA_WIDTH / 8),
    parameter int ID_WIDTH         = 8,
    parameter int DEST_WIDTH       = $clog2(M_COUNT + 1),
    parameter int USER_WIDTH       = 1,
    parameter int TDEST_ROUTE_BASE = 0
) (
    input  logic               clk,
    input  logic               rst,
    axis_demux_tdest_if.slave  s_axis,
    axis_demux_tdest_if.master m_axis
`ifdef AXIS_DEMUX_DROP_COUNT_EN
    ,
    input  logic               drop_count_clr,
    output logic [15:0]        drop_count
`endif
);

    localparam int IDX_W = $clog2(M_COUNT);
    localparam int SW    = DEST_WIDTH + 1;
    localparam logic [SW-1:0] BASE  = SW'(TDEST_ROUTE_BASE);
    localparam logic [SW-1:0] COUNT = SW'(M_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [KEEP_WIDTH-1:0] keep;
        logic                  last;
        logic [ID_WIDTH-1:0]   id;
        logic [DEST_WIDTH-1:0] dest;
        logic [USER_WIDTH-1:0] user;
    } beat_t;

    state_t state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [SW-1:0]    diff;
    logic             s_ready;
    logic [M_COUNT-1:0] wr;

    beat_t in_beat;

    beat_t [M_COUNT-1:0] out_q, out_d;
    beat_t [M_COUNT-1:0] skid_q, skid_d;
    logic  [M_COUNT-1:0] out_vld_q, out_vld_d;
    logic  [M_COUNT-1:0] skid_vld_q, skid_vld_d;
    logic  [M_COUNT-1:0] ready_q, ready_d;

    always_comb begin
        in_beat.data = s_axis.tdata;
        in_beat.keep = s_axis.tkeep;
        in_beat.last = s_axis.tlast;
        in_beat.id   = s_axis.tid;
        in_beat.dest = s_axis.tdest;
        in_beat.user = s_axis.tuser;
    end

    // Out-of-range and below-base tdest both land outside 0..M_COUNT-1.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        s_ready = 1'b0;
        diff    = {1'b0, s_axis.tdest} - BASE;
        unique case (state_q)
            IDLE: begin
                if (s_axis.tvalid) begin
                    sel_d   = diff[IDX_W-1:0];
                    state_d = (diff < COUNT) ? ROUTE : DROP;
                end
            end
            ROUTE: begin
                s_ready = ready_q[sel_q];
                if (s_axis.tvalid && s_ready && s_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr = '0;
        if (state_q == ROUTE && s_axis.tvalid && s_ready) begin
            wr[sel_q] = 1'b1;
        end
    end

    assign s_axis.tready = s_ready;

    // Ready is registered, so a second beat may arrive while the output stalls.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        ready_d    = ready_q;
        for (int k = 0; k < M_COUNT; k++) begin
            ready_d[k] = m_axis.tready[k]
                       || (!skid_vld_q[k] && (!out_vld_q[k] || !wr[k]));
            if (ready_q[k]) begin
                if (m_axis.tready[k] || !out_vld_q[k]) begin
                    out_vld_d[k] = wr[k];
                    if (wr[k]) begin
                        out_d[k] = in_beat;
                    end
                end else begin
                    skid_vld_d[k] = wr[k];
                    if (wr[k]) begin
                        skid_d[k] = in_beat;
                    end
                end
            end else if (m_axis.tready[k]) begin
                out_vld_d[k]  = skid_vld_q[k];
                out_d[k]      = skid_q[k];
                skid_vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            out_q      <= '0;
            skid_q     <= '0;
            out_vld_q  <= '0;
            skid_vld_q <= '0;
            ready_q    <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            out_vld_q  <= out_vld_d;
            skid_vld_q <= skid_vld_d;
            ready_q    <= ready_d;
        end
    end

    for (genvar k = 0; k < M_COUNT; k++) begin : g_out
        assign m_axis.tdata[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k].data;
        assign m_axis.tkeep[k*KEEP_WIDTH +: KEEP_WIDTH] =
            KEEP_ENABLE ? out_q[k].keep : {KEEP_WIDTH{1'b1}};
        assign m_axis.tlast[k]                          = out_q[k].last;
        assign m_axis.tid[k*ID_WIDTH +: ID_WIDTH]       = out_q[k].id;
        assign m_axis.tdest[k*DEST_WIDTH +: DEST_WIDTH] = out_q[k].dest;
        assign m_axis.tuser[k*USER_WIDTH +: USER_WIDTH] = out_q[k].user;
        assign m_axis.tvalid[k]                         = out_vld_q[k];
    end

`ifdef AXIS_DEMUX_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_count_clr) begin
            drop_cnt_d = '0;
        end else if (state_q == DROP && s_axis.tvalid && s_axis.tlast
                     && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule
